// File: rtl/alu_issue_seq_if.sv
// Stream, ALU and status signals of the ALU issue sequencer.
// The slave modport is the sequencer's view; master is its surroundings.
interface alu_issue_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rega;
    logic [31:0] in_regb;
    logic [31:0] alu_instruction;
    logic [31:0] alu_rega;
    logic [31:0] alu_regb;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic        err_valid;
    logic [31:0] err_instr;
    logic [15:0] stat_issued;
    logic [15:0] stat_rejected;

    modport slave (
        input  in_valid, in_instr, in_rega, in_regb,
        input  alu_result, alu_flags, out_ready,
        output in_ready, alu_instruction, alu_rega, alu_regb,
        output out_valid, out_instr, out_result, out_flags,
        output err_valid, err_instr, stat_issued, stat_rejected
    );

    modport master (
        output in_valid, in_instr, in_rega, in_regb,
        output alu_result, alu_flags, out_ready,
        input  in_ready, alu_instruction, alu_rega, alu_regb,
        input  out_valid, out_instr, out_result, out_flags,
        input  err_valid, err_instr, stat_issued, stat_rejected
    );
endinterface

// File: rtl/alu_issue_seq.sv
// FIFO-fed issue sequencer for a combinational MIPS ALU.
// Define ALU_ISSUE_SEQ_STATS_EN to enable the issue/reject counters.
module alu_issue_seq #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter logic [31:0] BUBBLE  = 32'hFC00_0000
) (
    input logic            clk,
    input logic            reset,
    alu_issue_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, GAP} state_t;

    state_t        state;
    state_t        state_n;
    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          legal;
    logic          issue;
    logic          reject;
    logic          capture;
    logic [31:0]   head_instr;
    logic [31:0]   head_rega;
    logic [31:0]   head_regb;
    logic [CW-1:0] cnt;
    logic [31:0]   iss_instr;
    logic [31:0]   iss_rega;
    logic [31:0]   iss_regb;
    logic [31:0]   res_instr;
    logic [31:0]   res_result;
    logic [2:0]    res_flags;
    logic          err_pulse;
    logic [31:0]   err_word;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    assign {head_instr, head_rega, head_regb} = mem[rptr];
    // Only register addresses 0 and 1 exist behind this ALU.
    assign legal = (head_instr[25:22] == 4'd0) && (head_instr[20:17] == 4'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {bus.in_instr, bus.in_rega, bus.in_regb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        issue   = 1'b0;
        reject  = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (legal) begin
                        issue   = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cnt == CW'(ALU_LAT - 1)) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_n = GAP;
            end
            GAP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            iss_instr  <= '0;
            iss_rega   <= '0;
            iss_regb   <= '0;
            res_instr  <= '0;
            res_result <= '0;
            res_flags  <= '0;
            err_pulse  <= 1'b0;
            err_word   <= '0;
        end else begin
            err_pulse <= reject;
            if (reject) err_word <= head_instr;
            if (issue) begin
                iss_instr <= head_instr;
                iss_rega  <= head_rega;
                iss_regb  <= head_regb;
                cnt       <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
            end
            if (capture) begin
                res_instr  <= iss_instr;
                res_result <= bus.alu_result;
                res_flags  <= bus.alu_flags;
            end
        end
    end

    // Bubble outside ISSUE so the ALU sees a change on every new issue.
    assign bus.alu_instruction = (state == ISSUE) ? iss_instr : BUBBLE;
    assign bus.alu_rega        = iss_rega;
    assign bus.alu_regb        = iss_regb;
    assign bus.in_ready        = !full;
    assign bus.out_valid       = (state == HOLD);
    assign bus.out_instr       = res_instr;
    assign bus.out_result      = res_result;
    assign bus.out_flags       = res_flags;
    assign bus.err_valid       = err_pulse;
    assign bus.err_instr       = err_word;

`ifdef ALU_ISSUE_SEQ_STATS_EN
    logic [15:0] n_issued;
    logic [15:0] n_rejected;

    always_ff @(posedge clk) begin
        if (reset) begin
            n_issued   <= '0;
            n_rejected <= '0;
        end else begin
            if (issue && n_issued != 16'hFFFF)
                n_issued <= n_issued + 1'b1;
            if (reject && n_rejected != 16'hFFFF)
                n_rejected <= n_rejected + 1'b1;
        end
    end

    assign bus.stat_issued   = n_issued;
    assign bus.stat_rejected = n_rejected;
`else
    assign bus.stat_issued   = 16'h0000;
    assign bus.stat_rejected = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq with a behavioural MIPS ALU.
// Build with ALU_ISSUE_SEQ_STATS_EN to expect live counters.
module tb_alu_issue_seq;
    localparam int          DEPTH   = 4;
    localparam int          ALU_LAT = 1;
    localparam logic [31:0] BUBBLE  = 32'hFC00_0000;
    localparam logic [31:0] ADD01   = 32'h0001_0020;
    localparam logic [31:0] SUB01   = 32'h0001_0022;
    localparam logic [31:0] AND01   = 32'h0001_0024;
    localparam logic [31:0] OR11    = 32'h0021_0025;
    localparam logic [31:0] ADD10   = 32'h0020_0020;
    localparam logic [31:0] BADRS   = 32'h0042_0020;
    localparam logic [31:0] BADRT   = 32'h0002_0020;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] result;
        logic [2:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [31:0] err_q[$];
    int   hs_cyc[$];
    int   run = 0;
    exp_t e;
    logic [31:0] ew;
    logic [31:0] alu_r;
    logic        alu_ov;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_issue_seq_if bus();

    alu_issue_seq #(
        .DEPTH(DEPTH),
        .ALU_LAT(ALU_LAT),
        .BUBBLE(BUBBLE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always_comb begin
        alu_r  = 32'hDEAD_BEEF;
        alu_ov = 1'b0;
        if (bus.alu_instruction[31:26] == 6'd0) begin
            case (bus.alu_instruction[5:0])
                6'h20: begin
                    alu_r  = bus.alu_rega + bus.alu_regb;
                    alu_ov = (bus.alu_rega[31] == bus.alu_regb[31]) &&
                             (alu_r[31] != bus.alu_rega[31]);
                end
                6'h22: begin
                    alu_r  = bus.alu_rega - bus.alu_regb;
                    alu_ov = (bus.alu_rega[31] != bus.alu_regb[31]) &&
                             (alu_r[31] != bus.alu_rega[31]);
                end
                6'h24: alu_r = bus.alu_rega & bus.alu_regb;
                6'h25: alu_r = bus.alu_rega | bus.alu_regb;
                default: alu_r = 32'hDEAD_BEEF;
            endcase
        end
    end

    assign bus.alu_result = alu_r;
    assign bus.alu_flags  = {alu_r == 32'd0, alu_r[31], alu_ov};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%h required=none",
                         bus.out_instr);
            end else begin
                e = exp_q.pop_front();
                check("out_instr", bus.out_instr, e.instr);
                check("out_result", bus.out_result, e.result);
                check("out_flags", 32'(bus.out_flags), 32'(e.flags));
            end
        end
        if (bus.err_valid) begin
            if (err_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_err actual=%h required=none",
                         bus.err_instr);
            end else begin
                ew = err_q.pop_front();
                check("err_instr", bus.err_instr, ew);
            end
        end
        if (bus.alu_instruction !== BUBBLE) begin
            run++;
        end else if (run > 0) begin
            check("issue_width", run, ALU_LAT);
            run = 0;
        end
    end

    task automatic push(input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input logic ok,
                        input logic [31:0] res, input logic [2:0] fl);
        bit rdy = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_rega  = a;
        bus.in_regb  = b;
        for (int i = 0; i < 200 && !rdy; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
        end
        if (!rdy) fail_now("push_accept");
        else if (ok) exp_q.push_back('{instr, res, fl});
        else err_q.push_back(instr);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && err_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0 || err_q.size() != 0) fail_now("drain");
        exp_q.delete();
        err_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int is_exp;
        int rj_exp;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_rega   = '0;
        bus.in_regb   = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_alu_instr", bus.alu_instruction, BUBBLE);
        check("rst_alu_rega", bus.alu_rega, 32'd0);
        check("rst_alu_regb", bus.alu_regb, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check("rst_err_valid", 32'(bus.err_valid), 32'd0);
        check("rst_err_instr", bus.err_instr, 32'd0);
        check("rst_stat_issued", 32'(bus.stat_issued), 32'd0);
        check("rst_stat_rejected", 32'(bus.stat_rejected), 32'd0);
        @(posedge clk);
        #1;

        push(ADD01, 32'd5, 32'd7, 1'b1, 32'd12, 3'b000);
        lat = 21;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, ALU_LAT + 2);
        drain();

        hs_cyc.delete();
        push(ADD01, 32'd5, 32'd7, 1'b1, 32'd12, 3'b000);
        push(ADD01, 32'd1, 32'd1, 1'b1, 32'd2, 3'b000);
        push(SUB01, 32'd3, 32'd3, 1'b1, 32'd0, 3'b100);
        drain();
        check("hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("gap0", hs_cyc[1] - hs_cyc[0], ALU_LAT + 3);
            check("gap1", hs_cyc[2] - hs_cyc[1], ALU_LAT + 3);
        end

        push(BADRS, 32'd1, 32'd2, 1'b0, 32'd0, 3'b000);
        push(BADRT, 32'd1, 32'd2, 1'b0, 32'd0, 3'b000);
        push(ADD10, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 3'b100);
        push(SUB01, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 3'b010);
        push(ADD01, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 3'b011);
        push(SUB01, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 3'b001);
        push(AND01, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1,
             32'h00F0_00F0, 3'b000);
        push(OR11, 32'h1234_0000, 32'h0000_5678, 1'b1,
             32'h1234_5678, 3'b000);
        drain();

        bus.out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++)
            push(ADD01, 32'(i), 32'(i), 1'b1, 32'(2 * i), 3'(i == 0 ? 4 : 0));
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        push(ADD01, 32'd100, 32'd23, 1'b1, 32'd123, 3'b000);
        drain();

        push(ADD01, 32'd2, 32'd3, 1'b1, 32'd5, 3'b000);
        push(SUB01, 32'd10, 32'd4, 1'b1, 32'd6, 3'b000);
        push(AND01, 32'hFF, 32'h0F, 1'b1, 32'h0F, 3'b000);
        push(OR11, 32'hF0, 32'h0F, 1'b1, 32'hFF, 3'b000);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.alu_instruction == SUB01);
        end
        if (!seen) fail_now("reach_issue");
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_alu_instr", bus.alu_instruction, BUBBLE);
        check("mid_rst_err_valid", 32'(bus.err_valid), 32'd0);
        check("mid_rst_stat", 32'(bus.stat_issued), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        push(ADD01, 32'd1, 32'd2, 1'b1, 32'd3, 3'b000);
        push(BADRS, 32'd0, 32'd0, 1'b0, 32'd0, 3'b000);
        push(ADD10, 32'd4, 32'd4, 1'b1, 32'd8, 3'b000);
        push(BADRT, 32'd0, 32'd0, 1'b0, 32'd0, 3'b000);
        push(SUB01, 32'd9, 32'd4, 1'b1, 32'd5, 3'b000);
        drain();
`ifdef ALU_ISSUE_SEQ_STATS_EN
        is_exp = 3;
        rj_exp = 2;
`else
        is_exp = 0;
        rj_exp = 0;
`endif
        check("stat_issued", 32'(bus.stat_issued), is_exp);
        check("stat_rejected", 32'(bus.stat_rejected), rj_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator-side sequencer for the combinational MIPS ALU.
- Accepts a stream of {instruction, regA, regB} packets from upstream and queues them in a small FIFO.
- Screens each packet for legal register addresses, issues it to the ALU, waits a fixed settle time, captures result and flags, and presents them on a valid/ready output stream.
- Inserts a bubble instruction between issues because the ALU re-evaluates only when its instruction input changes.

Parameters:
- DEPTH, 4, input FIFO entries; power of two, minimum 2.
- ALU_LAT, 1, cycles the ALU inputs are held before capture; minimum 1.
- BUBBLE, 32'hFC00_0000, instruction driven to the ALU when idle (op 111111, rs=0, rt=0; decodes to no operation).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream packet valid
- in_ready  out  1  FIFO not full
- in_instr  in  32  instruction
- in_rega  in  32  regA operand value
- in_regb  in  32  regB operand value
- alu_instruction  out  32  to ALU instruction
- alu_rega  out  32  to ALU regA
- alu_regb  out  32  to ALU regB
- alu_result  in  32  from ALU result
- alu_flags  in  3  from ALU flags: [2] zero, [1] negative, [0] overflow
- out_valid  out  1  result packet valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction that produced the result
- out_result  out  32  captured result
- out_flags  out  3  captured flags
- err_valid  out  1  one-cycle pulse: packet rejected
- err_instr  out  32  rejected instruction, held until the next reject
- stat_issued  out  16  see Optional Feature
- stat_rejected  out  16  see Optional Feature

Behaviour:
Reset and handshake:
- Synchronous reset, active-high, on clk.
- Reset clears the FIFO and sets state=IDLE, cnt=0.
- Reset values: alu_instruction=BUBBLE; alu_rega, alu_regb, out_*, err_*, and stats = 0; in_ready=1.
- Reset mid-operation discards any queued or in-flight packet; no output or error is emitted for it.
- Push occurs when in_valid & in_ready at a clk edge. in_ready = !full.
- Push and pop in the same cycle are allowed when not full. When full, push is blocked even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.

FSM states: IDLE, ISSUE, HOLD, GAP.
- IDLE, FIFO non-empty: pop the head.
  - If head rs (instr[25:21]) or rt (instr[20:16]) is not 5'b00000/5'b00001: err_valid=1 next cycle, err_instr=head, stay IDLE.
  - Otherwise: latch the packet into the issue registers, cnt=0, go to ISSUE.
- IDLE, FIFO empty: stay IDLE.
- ISSUE: alu_instruction/alu_rega/alu_regb = issue registers; cnt increments each cycle.
  - At the edge where cnt==ALU_LAT-1: out_result<=alu_result, out_flags<=alu_flags, out_instr<=issued instruction; go to HOLD.
- HOLD: out_valid=1 and out_* stable.
  - On out_ready at a clk edge: go to GAP.
  - Backpressure holds indefinitely; the FIFO continues to fill.
- GAP: one cycle, then go to IDLE.

Other rules:
- alu_instruction=BUBBLE in IDLE, HOLD and GAP. alu_rega/alu_regb keep their last values.
- Latency: with the FIFO empty and state IDLE, out_valid rises ALU_LAT+2 cycles after the accepting edge.
- Throughput with out_ready tied high: one result per ALU_LAT+3 cycles.
- A rejected packet costs one IDLE cycle; the next pop may occur on the following cycle.
- Back-to-back rejects produce back-to-back err_valid pulses.
- Results are bit-exact copies of the ALU outputs. No arithmetic is done in this block.

Optional Feature:
- Macro ALU_ISSUE_SEQ_STATS_EN.
- Defined:
  - stat_issued increments on each ISSUE entry.
  - stat_rejected increments on each reject.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: both ports tied to 16'h0000 and no counter flops are synthesized.
- Ports exist in both builds.

Test Plan:
- Push add (32'h0001_0020, rs=0, rt=1) with regA=5, regB=7, out_ready=1, behavioural ALU attached -> out_valid at accept+3 cycles (ALU_LAT=1), out_result=12, out_flags=3'b000, out_instr=32'h0001_0020.
- Push the same add twice with regA=5/regB=7, then regA=1/regB=1 -> results 12 then 2; alu_instruction=BUBBLE for at least one cycle between the issues.
- Push instruction 32'h0042_0020 (rs=2) -> err_valid for exactly 1 cycle, err_instr=32'h0042_0020, no out_valid; the following valid packet completes normally.
- Hold out_ready=0, push DEPTH+2 packets -> in_ready low after DEPTH+1 accepts (one in HOLD, DEPTH queued); release out_ready -> all results emitted in order with no loss.
- Assert reset during ISSUE with 2 packets queued -> next cycle: out_valid=0, in_ready=1, alu_instruction=BUBBLE, FIFO empty; no stale result appears afterwards.
- With ALU_ISSUE_SEQ_STATS_EN defined: 3 valid + 2 invalid packets -> stat_issued=3, stat_rejected=2. Without the macro -> both 0.
